scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
- Controller for the eight-digit scroller datapath: dual-port message BRAM (port A 16-bit write, port B 32-bit read), circular 8-digit shift register and display-source mux.
- Sequences switch-entry programming of up to 2**MSG_AW 32-bit messages as low/high 16-bit halves.
- Plays the stored messages back in order, each for a fixed number of full rotations, with pause/resume.
- Sits between the debounced button pulses and shift tick on one side and the BRAM, shift register and mux select on the other.

Parameters:
MSG_AW, 2, message index width; number of message slots = 2**MSG_AW
ROT_PER_MSG, 2, full 8-digit rotations shown per message before advancing (>=1)
BRAM_LAT, 1, port-B read latency in clocks (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
prog_btn  in  1  one-cycle pulse: start programming / commit current half
run_btn  in  1  one-cycle pulse: abort-and-play / pause / resume
shift_tick  in  1  one-cycle pulse at scroll rate
wea  out  1  port-A write enable, one cycle per committed half
addra  out  MSG_AW+1  port-A address = {wr_idx, half}; half 0 = low 16 bits
addrb  out  MSG_AW  port-B address = rd_idx
load_en  out  1  one-cycle parallel load of shift register
shift_en  out  1  rotate shift register this cycle (already gated with shift_tick)
disp_src  out  2  0 = shift register, 1 = switches on low 4 digits, 2 = switches on high 4 digits
cur_msg  out  MSG_AW  message index currently loaded or being written
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state = IDLE; wr_idx = rd_idx = msg_cnt = tick_cnt = wait_cnt = 0; wea, load_en, shift_en, busy = 0; addra = addrb = cur_msg = 0; disp_src = 0.
- Registered outputs: wea, addra, addrb, load_en, disp_src. Combinational output: shift_en = (state==SCROLL) & shift_tick.
- If prog_btn and run_btn pulse in the same cycle, prog_btn wins everywhere.
- IDLE:
  - disp_src = 0.
  - prog_btn -> PROG_LO; wr_idx = 0; msg_cnt = 0.
  - run_btn -> RD_WAIT with rd_idx = 0, only if msg_cnt > 0; otherwise ignored.
- PROG_LO:
  - disp_src = 1.
  - prog_btn -> wea = 1 for one cycle at addra = {wr_idx,0} -> PROG_HI.
- PROG_HI:
  - disp_src = 2.
  - prog_btn -> wea = 1 at addra = {wr_idx,1}; msg_cnt = wr_idx+1.
  - If wr_idx == 2**MSG_AW-1 -> RD_WAIT with rd_idx = 0; else wr_idx++ -> PROG_LO.
- run_btn in PROG_LO/PROG_HI:
  - Abort; the half-written message is discarded (not counted).
  - -> RD_WAIT with rd_idx = 0 if msg_cnt > 0, else -> IDLE.
- RD_WAIT:
  - addrb = rd_idx, registered on entry; stay exactly BRAM_LAT cycles (wait_cnt) -> LOAD.
  - prog_btn/run_btn ignored here.
- LOAD:
  - load_en = 1 for exactly one cycle; tick_cnt = 0 -> SCROLL.
  - Buttons ignored.
- SCROLL:
  - disp_src = 0.
  - On each shift_tick: tick_cnt++. When tick_cnt reaches 8*ROT_PER_MSG-1 and a tick arrives:
    - rd_idx = (rd_idx+1 == msg_cnt) ? 0 : rd_idx+1 (wrap);
    - -> RD_WAIT.
  - The final rotation's tick still asserts shift_en, so the display is back at its load position when the next load occurs.
  - run_btn -> PAUSE; prog_btn -> PROG_LO (wr_idx = 0, msg_cnt = 0).
- PAUSE:
  - disp_src = 0; shift_en = 0; tick_cnt held; ticks ignored.
  - run_btn -> SCROLL, continuing the count.
  - prog_btn -> PROG_LO as above.
- cur_msg = wr_idx in PROG states, rd_idx otherwise.
- Single-message case (msg_cnt = 1): after each completed display period, rd_idx stays 0 and the message is re-read and reloaded.
- Counter widths: tick_cnt wide enough for 8*ROT_PER_MSG-1; msg_cnt has MSG_AW+1 bits.

Test Plan:
- Reset mid-SCROLL (rst_n low 3 cycles, asynchronous to clk) -> all outputs 0, state IDLE immediately, no load_en after release; run_btn then ignored (msg_cnt = 0).
- Program 4 messages: 8 prog_btn pulses, SW = 0x1111,0x2222,...,0x8888 -> wea pulses at addra 0..7 in order with disp_src alternating 1,2; then addrb = 0, load_en exactly BRAM_LAT cycles after RD_WAIT entry.
- ROT_PER_MSG = 2, 4 messages: count shift_en -> 16 per message; addrb sequence 0,1,2,3,0 with one load_en per message.
- Abort: program message 0 fully, write low half of message 1, then run_btn -> playback of message 0 only; addrb stays 0, reload every 16 ticks.
- Pause: run_btn after 5 ticks in SCROLL, 10 ticks while paused, run_btn again -> shift_en = 0 during pause; next load occurs after 11 further ticks (16 total).
- Simultaneous prog_btn and run_btn in SCROLL -> PROG_LO, disp_src = 1, msg_cnt = 0, wea = 0 that cycle.

Source files
------------

// File: rtl/scroll_sequencer.sv
// scroll_sequencer
//   Controller for the eight-digit scroller. It sequences switch-entry
//   programming of up to 2**MSG_AW 32-bit messages, written as low and high
//   16-bit halves. It then plays the stored messages back in order. Each
//   message is shown for ROT_PER_MSG full rotations, and playback can be
//   paused and resumed.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   prog_btn    pulse: start programming / commit current half (wins over run_btn)
//   run_btn     pulse: abort-and-play / pause / resume
//   shift_tick  pulse at scroll rate
//   wea         port-A write enable, one cycle per committed half
//   addra       port-A address {wr_idx, half}, half 0 = low 16 bits
//   addrb       port-B address (message being read)
//   load_en     one-cycle parallel load of the shift register
//   shift_en    rotate shift register (combinational, gated by shift_tick)
//   disp_src    0 = shift register, 1 = switches low digits, 2 = switches high digits
//   cur_msg     message index being written (PROG states) or shown
//   busy        high in every state except IDLE
module scroll_sequencer #(
  parameter int MSG_AW      = 2,
  parameter int ROT_PER_MSG = 2,
  parameter int BRAM_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_btn,
  input  logic              run_btn,
  input  logic              shift_tick,
  output logic              wea,
  output logic [MSG_AW:0]   addra,
  output logic [MSG_AW-1:0] addrb,
  output logic              load_en,
  output logic              shift_en,
  output logic [1:0]        disp_src,
  output logic [MSG_AW-1:0] cur_msg,
  output logic              busy
);

  localparam int TCW = $clog2(8 * ROT_PER_MSG);
  localparam int WCW = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
  localparam logic [TCW-1:0]    TICK_LAST = TCW'(8 * ROT_PER_MSG - 1);
  localparam logic [WCW-1:0]    WAIT_LAST = WCW'(BRAM_LAT - 1);
  localparam logic [MSG_AW-1:0] LAST_IDX  = {MSG_AW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_PROG_LO, S_PROG_HI, S_RD_WAIT, S_LOAD, S_SCROLL, S_PAUSE
  } state_t;

  state_t              state_q, state_d;
  logic [MSG_AW-1:0]   wr_idx_q, wr_idx_d;
  logic [MSG_AW-1:0]   rd_idx_q, rd_idx_d;
  logic [MSG_AW:0]     msg_cnt_q, msg_cnt_d;
  logic [TCW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic                wea_q, wea_d;
  logic [MSG_AW:0]     addra_q, addra_d;
  logic [MSG_AW-1:0]   addrb_q, addrb_d;
  logic                load_en_q, load_en_d;
  logic [1:0]          disp_src_q, disp_src_d;

  // prog_btn has priority: a simultaneous run_btn is simply dropped.
  logic prog_p, run_p, final_tick;
  assign prog_p     = prog_btn;
  assign run_p      = run_btn & ~prog_btn;
  assign final_tick = shift_tick && (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      msg_cnt_q  <= '0;
      tick_cnt_q <= '0;
      wait_cnt_q <= '0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      load_en_q  <= 1'b0;
      disp_src_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      msg_cnt_q  <= msg_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      addrb_q    <= addrb_d;
      load_en_q  <= load_en_d;
      disp_src_q <= disp_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    msg_cnt_d  = msg_cnt_q;
    tick_cnt_d = tick_cnt_q;
    wait_cnt_d = wait_cnt_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    addrb_d    = addrb_q;

    case (state_q)
      S_IDLE: begin
        if (prog_p) begin
          state_d   = S_PROG_LO;
          wr_idx_d  = '0;
          msg_cnt_d = '0;
        end else if (run_p && msg_cnt_q != '0) begin
          state_d  = S_RD_WAIT;
          rd_idx_d = '0;
        end
      end

      S_PROG_LO, S_PROG_HI: begin
        if (prog_p) begin
          wea_d   = 1'b1;
          addra_d = {wr_idx_q, (state_q == S_PROG_HI)};
          if (state_q == S_PROG_LO) begin
            state_d = S_PROG_HI;
          end else begin
            msg_cnt_d = {1'b0, wr_idx_q} + (MSG_AW+1)'(1);
            if (wr_idx_q == LAST_IDX) begin
              state_d  = S_RD_WAIT;
              rd_idx_d = '0;
            end else begin
              wr_idx_d = wr_idx_q + MSG_AW'(1);
              state_d  = S_PROG_LO;
            end
          end
        end else if (run_p) begin
          // Abort: msg_cnt only counts completed messages, so the
          // half-written one is discarded automatically.
          if (msg_cnt_q != '0) begin
            state_d  = S_RD_WAIT;
            rd_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_LOAD;
        else                         wait_cnt_d = wait_cnt_q + WCW'(1);
      end

      S_LOAD: begin
        tick_cnt_d = '0;
        state_d    = S_SCROLL;
      end

      S_SCROLL: begin
        if (prog_p) begin
          state_d   = S_PROG_LO;
          wr_idx_d  = '0;
          msg_cnt_d = '0;
        end else if (final_tick) begin
          // The display has just returned to its load position. A run_btn
          // landing on this exact tick is dropped so the period completes.
          state_d = S_RD_WAIT;
          if (({1'b0, rd_idx_q} + (MSG_AW+1)'(1)) == msg_cnt_q) rd_idx_d = '0;
          else                                                  rd_idx_d = rd_idx_q + MSG_AW'(1);
        end else begin
          // Count every tick that actually rotates the register, even one
          // arriving with run_btn, so the count tracks the display.
          if (shift_tick) tick_cnt_d = tick_cnt_q + TCW'(1);
          if (run_p)      state_d    = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (prog_p) begin
          state_d   = S_PROG_LO;
          wr_idx_d  = '0;
          msg_cnt_d = '0;
        end else if (run_p) begin
          state_d = S_SCROLL;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Port-B address is latched on entry to RD_WAIT; the wait counter
    // restarts so LOAD lands exactly BRAM_LAT cycles after the address.
    if (state_d == S_RD_WAIT && state_q != S_RD_WAIT) begin
      addrb_d    = rd_idx_d;
      wait_cnt_d = '0;
    end
  end

  // Registered decodes of the next state keep these outputs aligned with
  // the state they belong to.
  always_comb begin
    load_en_d = (state_d == S_LOAD);
    case (state_d)
      S_PROG_LO: disp_src_d = 2'd1;
      S_PROG_HI: disp_src_d = 2'd2;
      default:   disp_src_d = 2'd0;
    endcase
  end

  assign wea      = wea_q;
  assign addra    = addra_q;
  assign addrb    = addrb_q;
  assign load_en  = load_en_q;
  assign disp_src = disp_src_q;
  assign shift_en = (state_q == S_SCROLL) && shift_tick;
  assign busy     = (state_q != S_IDLE);
  assign cur_msg  = (state_q == S_PROG_LO || state_q == S_PROG_HI) ? wr_idx_q : rd_idx_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
module tb_scroll_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_btn = 1'b0, run_btn = 1'b0, shift_tick = 1'b0;
  logic       wea, load_en, shift_en, busy;
  logic [2:0] addra;
  logic [1:0] addrb, disp_src, cur_msg;

  scroll_sequencer #(.MSG_AW(2), .ROT_PER_MSG(2), .BRAM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .prog_btn(prog_btn), .run_btn(run_btn),
    .shift_tick(shift_tick), .wea(wea), .addra(addra), .addrb(addrb),
    .load_en(load_en), .shift_en(shift_en), .disp_src(disp_src),
    .cur_msg(cur_msg), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic se_seen;

  typedef struct {
    logic p, r, t;
    logic se, wea;
    logic [2:0] addra;
    logic [1:0] addrb;
    logic ld;
    logic [1:0] disp;
    logic busy;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic p, r, t, se, w, input logic [2:0] aa,
                              input logic [1:0] ab, input logic ld,
                              input logic [1:0] ds, input logic bz, input logic [1:0] cm);
    vec_t v;
    v.p = p; v.r = r; v.t = t; v.se = se; v.wea = w; v.addra = aa; v.addrb = ab;
    v.ld = ld; v.disp = ds; v.busy = bz; v.cur = cm;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // One clock: inputs driven after negedge, shift_en sampled before the
  // edge, registered outputs observed 1 ns after the edge.
  task automatic step(input logic p, input logic r, input logic t);
    @(negedge clk);
    prog_btn = p; run_btn = r; shift_tick = t;
    #1 se_seen = shift_en;
    @(posedge clk);
    #1;
    prog_btn = 1'b0; run_btn = 1'b0; shift_tick = 1'b0;
  endtask

  function automatic logic [12:0] pack_act();
    return {se_seen, wea, addra, addrb, load_en, disp_src, busy, cur_msg};
  endfunction

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(vecs[i].p, vecs[i].r, vecs[i].t);
      check($sformatf("vec%0d", i), int'(pack_act()),
            int'({vecs[i].se, vecs[i].wea, vecs[i].addra, vecs[i].addrb,
                  vecs[i].ld, vecs[i].disp, vecs[i].busy, vecs[i].cur}));
    end
  endtask

  // Tick every other cycle until load_en; returns number of shift_en seen.
  task automatic run_to_load(output int ticks, output bit got);
    ticks = 0; got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      step(1'b0, 1'b0, c[0]);
      if (se_seen) ticks++;
      if (load_en) got = 1'b1;
    end
  endtask

  task automatic period(input string name, input int exp_ticks, input int exp_addr);
    int n; bit got;
    run_to_load(n, got);
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no load_en expected load_en within 400 cycles", name);
    end else begin
      check({name, "_ticks"}, n, exp_ticks);
      check({name, "_addrb"}, int'(addrb), exp_addr);
      check({name, "_cur"}, int'(cur_msg), exp_addr);
    end
  endtask

  initial begin
    int n;
    //              p r t se w  aa ab ld ds bz cm
    vecs[0]  = mk(0,1,0, 0,0, 0, 0, 0, 0, 0, 0); // run ignored, nothing stored
    vecs[1]  = mk(1,0,0, 0,0, 0, 0, 0, 1, 1, 0);
    vecs[2]  = mk(1,0,0, 0,1, 0, 0, 0, 2, 1, 0);
    vecs[3]  = mk(1,0,0, 0,1, 1, 0, 0, 1, 1, 1);
    vecs[4]  = mk(1,0,0, 0,1, 2, 0, 0, 2, 1, 1);
    vecs[5]  = mk(1,0,0, 0,1, 3, 0, 0, 1, 1, 2);
    vecs[6]  = mk(1,0,0, 0,1, 4, 0, 0, 2, 1, 2);
    vecs[7]  = mk(1,0,0, 0,1, 5, 0, 0, 1, 1, 3);
    vecs[8]  = mk(1,0,0, 0,1, 6, 0, 0, 2, 1, 3);
    vecs[9]  = mk(1,0,0, 0,1, 7, 0, 0, 0, 1, 0); // last half -> RD_WAIT
    vecs[10] = mk(0,0,0, 0,0, 7, 0, 1, 0, 1, 0); // load one cycle later
    vecs[11] = mk(0,0,1, 0,0, 7, 0, 0, 0, 1, 0); // tick during LOAD: no shift
    // abort sequence, starting from IDLE with addra=7, addrb=1
    vecs[12] = mk(1,0,0, 0,0, 7, 1, 0, 1, 1, 0);
    vecs[13] = mk(1,0,0, 0,1, 0, 1, 0, 2, 1, 0);
    vecs[14] = mk(1,0,0, 0,1, 1, 1, 0, 1, 1, 1);
    vecs[15] = mk(1,0,0, 0,1, 2, 1, 0, 2, 1, 1);
    vecs[16] = mk(0,1,0, 0,0, 2, 0, 0, 0, 1, 0); // abort -> RD_WAIT msg 0
    vecs[17] = mk(0,0,0, 0,0, 2, 0, 1, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    se_seen = shift_en;
    check("reset_state", int'(pack_act()), 0);

    apply(0, 11);

    // Four messages in turn, 16 shifts each, wrapping back to 0.
    period("play1", 16, 1);
    period("play2", 16, 2);
    period("play3", 16, 3);
    period("play0", 16, 0);

    // Pause after 5 ticks, 10 ticks ignored, resume: 11 more to the load.
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (se_seen) n++;
    end
    check("pre_pause_ticks", n, 5);
    step(1'b0, 1'b1, 1'b0);
    check("pause_busy_disp", int'({busy, disp_src, load_en}), int'({1'b1, 2'd0, 1'b0}));
    n = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (se_seen) n++;
    end
    check("paused_shift_en", n, 0);
    step(1'b0, 1'b1, 1'b0);
    period("resume", 11, 1);

    // Simultaneous buttons in SCROLL: prog wins, msg_cnt cleared.
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("both_btn", int'({wea, disp_src, busy, cur_msg}), int'({1'b0, 2'd1, 1'b1, 2'd0}));
    step(1'b0, 1'b1, 1'b0);
    check("abort_empty_idle", int'({busy, disp_src}), 0);

    // Abort after one full message plus a low half: only message 0 plays.
    apply(12, 17);
    period("single_a", 16, 0);
    period("single_b", 16, 0);

    // Asynchronous reset mid-SCROLL.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    shift_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", int'({shift_en, wea, addra, addrb, load_en, disp_src, busy, cur_msg}), 0);
    shift_tick = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b0, 1'b1);
      if (load_en || busy || se_seen) n++;
    end
    check("post_reset_quiet", n, 0);
    step(1'b0, 1'b1, 1'b0);
    check("run_after_reset", int'({busy, load_en, addrb}), 0);
    step(1'b0, 1'b0, 1'b0);
    check("run_after_reset2", int'({busy, load_en}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
